// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: Status/Cause/EPC plus the Count/Compare timer,
// with edge-detected external interrupt lines and an ack/eret handshake.
module cp0_irq_ctrl #(
  parameter int NUM_IRQ = 2,
  parameter int TIMER_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [4:0]          addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [31:0]         epc_in,
  input  logic                int_ack,
  input  logic                eret,
  output logic                int_req,
  output logic [2:0]          int_id
);

  logic [NUM_IRQ-1:0] irqQ;
  logic               ie;
  logic [NUM_IRQ-1:0] imExt;
  logic               imTmr;
  logic [NUM_IRQ-1:0] ipExt;
  logic               ipTmr;
  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] compare;
  logic [31:0]        epc;

  logic               wrEn;
  logic               ackOk;
  logic [NUM_IRQ-1:0] pendExt;
  logic               pendTmr;
  logic [NUM_IRQ-1:0] extClr;
  logic               tmrClr;

  assign wrEn    = we & ~stall;
  assign ackOk   = int_ack & int_req & ~stall;
  assign pendExt = ipExt & imExt;
  assign pendTmr = ipTmr & imTmr;
  assign int_req = ie & (pendTmr | (|pendExt));

  always_comb begin
    extClr = '0;
    tmrClr = 1'b0;
    if (wrEn && addr == 5'd13) begin
      extClr = wdata[8 +: NUM_IRQ];
      tmrClr = wdata[15];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irqQ    <= '0;
      ie      <= 1'b0;
      imExt   <= '0;
      imTmr   <= 1'b0;
      ipExt   <= '0;
      ipTmr   <= 1'b0;
      count   <= '0;
      compare <= '1;
      epc     <= '0;
    end else begin
      irqQ  <= irq_in;
      // A fresh edge overrides a W1C clear of the same bit.
      ipExt <= (ipExt & ~extClr) | (irq_in & ~irqQ);

      if (!stall) begin
        if (wrEn && addr == 5'd9) count <= wdata[TIMER_W-1:0];
        else                      count <= count + 1'b1;
      end

      if (wrEn && addr == 5'd11) begin
        compare <= wdata[TIMER_W-1:0];
        ipTmr   <= 1'b0;
      end else if (!stall && count == compare) begin
        ipTmr <= 1'b1;
      end else if (tmrClr) begin
        ipTmr <= 1'b0;
      end

      if (wrEn && addr == 5'd12) begin
        ie    <= wdata[0];
        imExt <= wdata[8 +: NUM_IRQ];
        imTmr <= wdata[15];
      end
      // Accepted ack outranks both eret and an MTC0 to IE/EPC.
      if (ackOk)                ie <= 1'b0;
      else if (eret && !stall)  ie <= 1'b1;

      if (ackOk)                         epc <= epc_in;
      else if (wrEn && addr == 5'd14)    epc <= wdata;
    end
  end

  always_comb begin
    int_id = '0;
    if (int_req) begin
      if (pendTmr) begin
        int_id = 3'd7;
      end else begin
        for (int unsigned i = 0; i < NUM_IRQ; i++)
          if (pendExt[i]) int_id = i[2:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      5'd9:  rdata[TIMER_W-1:0] = count;
      5'd11: rdata[TIMER_W-1:0] = compare;
      5'd12: begin
        rdata[0]            = ie;
        rdata[8 +: NUM_IRQ] = imExt;
        rdata[15]           = imTmr;
      end
      5'd13: begin
        rdata[8 +: NUM_IRQ] = ipExt;
        rdata[15]           = ipTmr;
      end
      5'd14: rdata = epc;
      default: rdata = '0;
    endcase
  end

endmodule
